coax_tx: RTL and testbench

Bi-phase (Manchester) serial transmitter for the 3270 coax link, the transmit-side counterpart of `coax_rx`. It accepts 10-bit words over a ready/strobe handshake and drives the single-ended `tx` line. Each frame it sends consists of a start sequence, one or more sync + data + parity groups, and an end sequence, with framing and bit timing matching what `coax_rx` decodes. Consecutive words loaded in time are sent in one frame.

---
 rtl/coax_tx.sv | 174 +++++++++++++++++
 tb/tb_coax_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_tx.sv
// Bi-phase (Manchester) transmitter for the 3270 coax link.
// Sends start sequence, sync/data/parity groups per word, then end sequence.
module coax_tx #(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       strobe,
  output logic       ready,
  output logic       active,
  output logic       tx
);

  localparam int unsigned HALF = CLOCKS_PER_BIT / 2;
  localparam int unsigned TW   = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned CW   = 4;
  localparam int unsigned DW   = 10;

  typedef enum logic [2:0] {
    IDLE,
    START_SEQUENCE,
    SYNC_BIT,
    DATA_BIT,
    PARITY_BIT,
    END_SEQUENCE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   word_q, word_d;
  logic [DW-1:0]   hold_q;
  logic            ready_q;
  logic            active_q;
  logic            tx_q, tx_d;
  logic            xfer;
  logic            bit_end;
  logic            first_half;
  logic            cur_bit;

  assign bit_end = (timer_q == TW'(CLOCKS_PER_BIT - 1));

  // Next state, counters, and the line level for the upcoming cycle
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    xfer       = 1'b0;
    tx_d       = 1'b0;
    first_half = 1'b0;
    cur_bit    = 1'b0;

    if (state_q != IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (!ready_q || strobe) begin
          state_d = START_SEQUENCE;
          timer_d = '0;
          cnt_d   = '0;
        end
      end
      START_SEQUENCE: begin
        if (bit_end) begin
          if (cnt_q == CW'(7)) begin
            state_d = SYNC_BIT;
            cnt_d   = '0;
            word_d  = hold_q;
            xfer    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SYNC_BIT: begin
        if (bit_end) begin
          state_d = DATA_BIT;
          cnt_d   = '0;
        end
      end
      DATA_BIT: begin
        if (bit_end) begin
          if (cnt_q == CW'(9)) begin
            state_d = PARITY_BIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PARITY_BIT: begin
        // A word already waiting extends the current frame
        if (bit_end) begin
          if (!ready_q) begin
            state_d = SYNC_BIT;
            word_d  = hold_q;
            xfer    = 1'b1;
          end else begin
            state_d = END_SEQUENCE;
          end
          cnt_d = '0;
        end
      end
      END_SEQUENCE: begin
        if (bit_end) begin
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    first_half = (timer_d < TW'(HALF));

    case (state_d)
      START_SEQUENCE: begin
        // Five quiesce ones, then low 3H / high 3H code violation
        if (cnt_d < CW'(5)) tx_d = first_half;
        else                tx_d = (cnt_d == CW'(7)) || ((cnt_d == CW'(6)) && !first_half);
      end
      SYNC_BIT: tx_d = first_half;
      DATA_BIT: begin
        cur_bit = word_d[CW'(9) - cnt_d];
        tx_d    = cur_bit ? first_half : !first_half;
      end
      PARITY_BIT: begin
        cur_bit = ~^word_d;
        tx_d    = cur_bit ? first_half : !first_half;
      end
      END_SEQUENCE: tx_d = (cnt_d == CW'(0)) ? !first_half : 1'b1;
      default: tx_d = 1'b0;
    endcase
  end

  // State register and single-entry holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      hold_q   <= '0;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      tx_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      active_q <= (state_d != IDLE);
      tx_q     <= tx_d;
      if (xfer) begin
        ready_q <= 1'b1;
      end else if (strobe && ready_q) begin
        hold_q  <= data;
        ready_q <= 1'b0;
      end
    end
  end

  assign ready  = ready_q;
  assign active = active_q;
  assign tx     = tx_q;

endmodule

// File: tb/tb_coax_tx.sv
// Scoreboard bench for coax_tx: frame waveforms are built from the line-code
// rules, queued per clock, and compared by an independent negedge monitor.
module tb_coax_tx;

  localparam int unsigned CPB = 8;
  localparam int B = CPB;
  localparam int H = CPB / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       strobe = 1'b0;
  logic [9:0] data = '0;
  logic       ready, active, tx;

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .data(data), .strobe(strobe),
    .ready(ready), .active(active), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic tx; logic rdy; } exp_t;
  exp_t expq[$];
  int   lenq[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0, idle_chk = 1'b0, fin_chk = 1'b0;
  int mon_cnt = 0;
  bit prev_act = 1'b0;

  int         plan_n;
  logic [9:0] plan_w[4];
  int         plan_at[4];
  int         plan_end_at;
  logic [9:0] plan_end_w;
  bit         st[$];
  bit         rd[$];

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: pops one expected sample per active cycle
  always @(negedge clk) begin
    exp_t e;
    int   l;
    if (fin_chk) begin
      chk("queue_drained", expq.size() + lenq.size(), 0);
    end
    if (idle_chk) begin
      chk("idle_tx", int'(tx), 0);
      chk("idle_active", int'(active), 0);
      chk("idle_ready", int'(ready), 1);
    end
    if (!mon_en) begin
      mon_cnt  = 0;
      prev_act = 1'b0;
    end else begin
      if (active) begin
        if (expq.size() == 0) begin
          chk("unexpected_active", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("tx", int'(tx), int'(e.tx));
          chk("ready", int'(ready), int'(e.rdy));
        end
        mon_cnt++;
      end else begin
        chk("gap_tx", int'(tx), 0);
        if (prev_act) begin
          l = (lenq.size() != 0) ? lenq.pop_front() : -1;
          chk("frame_len", mon_cnt, l);
          mon_cnt = 0;
        end
      end
      prev_act = active;
    end
  end

  task automatic add_level(input bit v, input int n);
    repeat (n) st.push_back(v);
  endtask

  task automatic add_bit(input bit b);
    add_level(b, H);
    add_level(!b, H);
  endtask

  function automatic int pick(input int lo, input int hi);
    case ($urandom_range(0, 3))
      0:       return lo;
      1:       return hi;
      default: return lo + int'($urandom_range(0, unsigned'(hi - lo)));
    endcase
  endfunction

  task automatic random_plan(input logic [9:0] w0, input bit allow_end);
    plan_n     = int'($urandom_range(1, 3));
    plan_w[0]  = w0;
    plan_at[0] = 0;
    for (int j = 1; j < plan_n; j++) begin
      plan_w[j]  = 10'($urandom);
      plan_at[j] = pick(1 + 8*B + (j-1)*12*B, 8*B + j*12*B - 1);
    end
    plan_end_at = -1;
    plan_end_w  = 10'($urandom);
    if (allow_end && $urandom_range(0, 2) == 0)
      plan_end_at = pick(8*B + plan_n*12*B, 10*B + plan_n*12*B);
  endtask

  // Build expected frame from line-code rules, queue it, then drive strobes.
  // Relative cycle 0 is the strobe (or pre-loaded idle) cycle; entry i is cycle i+1.
  task automatic do_frame(input bit chained);
    int  len, lo, hi;
    bit  real_s;
    exp_t e;
    st.delete();
    rd.delete();
    repeat (5) add_bit(1'b1);
    add_level(1'b0, 3*H);
    add_level(1'b1, 3*H);
    for (int j = 0; j < plan_n; j++) begin
      add_bit(1'b1);
      for (int k = 9; k >= 0; k--) add_bit(plan_w[j][k]);
      add_bit(~^plan_w[j]);
    end
    add_bit(1'b0);
    add_level(1'b1, 2*H);
    len = st.size();
    for (int i = 0; i < len; i++) rd.push_back(1'b1);
    for (int j = 0; j < plan_n; j++) begin
      lo = (j == 0) ? 1 : plan_at[j] + 1;
      hi = 8*B + j*12*B;
      for (int c = lo; c <= hi; c++) rd[c-1] = 1'b0;
    end
    if (plan_end_at >= 0)
      for (int c = plan_end_at + 1; c <= len; c++) rd[c-1] = 1'b0;
    for (int i = 0; i < len; i++) begin
      e.tx  = st[i];
      e.rdy = rd[i];
      expq.push_back(e);
    end
    lenq.push_back(len);

    if (!chained) begin
      strobe = 1'b1;
      data   = plan_w[0];
    end else begin
      strobe = ($urandom_range(0, 1) == 1);
      data   = 10'($urandom);
    end
    @(posedge clk); #1;
    for (int c = 1; c <= len; c++) begin
      strobe = 1'b0;
      data   = 10'($urandom);
      real_s = 1'b0;
      for (int j = 1; j < plan_n; j++) begin
        if (c == plan_at[j]) begin
          strobe = 1'b1;
          data   = plan_w[j];
          real_s = 1'b1;
        end
      end
      if (c == plan_end_at) begin
        strobe = 1'b1;
        data   = plan_end_w;
        real_s = 1'b1;
      end
      if (!real_s && !rd[c-1] && ($urandom_range(0, 3) == 0 || c == 10))
        strobe = 1'b1;
      @(posedge clk); #1;
    end
    strobe = 1'b0;
  endtask

  task automatic run_plan();
    int depth = 0;
    do_frame(1'b0);
    while (plan_end_at >= 0) begin
      random_plan(plan_end_w, depth < 2);
      depth++;
      do_frame(1'b1);
    end
    repeat ($urandom_range(0, 4)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_plan(input int n, input logic [9:0] w0, input logic [9:0] w1,
                          input int at1, input int end_at);
    plan_n      = n;
    plan_w[0]   = w0;
    plan_w[1]   = w1;
    plan_at[0]  = 0;
    plan_at[1]  = at1;
    plan_end_at = end_at;
    plan_end_w  = 10'($urandom);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    idle_chk = 1'b1;
    repeat (64) begin
      @(posedge clk); #1;
    end
    idle_chk = 1'b0;
    mon_en   = 1'b1;

    set_plan(1, 10'b0110110011, 10'h0, 0, -1);  run_plan();
    set_plan(1, 10'b0000000001, 10'h0, 0, -1);  run_plan();
    set_plan(2, 10'h155, 10'h2AA, 100, -1);     run_plan();
    set_plan(2, 10'h3C5, 10'h0F0, 159, -1);     run_plan();
    set_plan(2, 10'h201, 10'h1FE, 65, -1);      run_plan();
    set_plan(1, 10'h0AB, 10'h0, 0, 160);        run_plan();
    set_plan(1, 10'h3FF, 10'h0, 0, 176);        run_plan();

    // Abort a frame with reset at cycle 80
    mon_en = 1'b0;
    strobe = 1'b1;
    data   = 10'($urandom);
    @(posedge clk); #1;
    strobe = 1'b0;
    repeat (79) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    idle_chk = 1'b1;
    @(posedge clk); #1;
    idle_chk = 1'b0;
    mon_en   = 1'b1;

    set_plan(1, 10'h2D6, 10'h0, 0, -1);  run_plan();
    repeat (25) begin
      random_plan(10'($urandom), 1'b1);
      run_plan();
    end

    repeat (4) begin
      @(posedge clk); #1;
    end
    fin_chk = 1'b1;
    @(posedge clk); #1;
    fin_chk = 1'b0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
